game_judge: RTL and testbench

- Game-side judge: the other end of the round controller's state/finish handshake.
- Consumes the controller's round state, mode and target value, plus decoded keystrokes and the current target character from the text store.
- Scores typing during INGAME and raises finish when the round target is met or the text runs out.
- After the round, computes words-per-minute with a sequential divider for the seven-segment/VGA display path.

---
 rtl/game_judge_pkg.sv | 23 ++
 rtl/game_judge_wpm_div.sv | 89 ++++++++
 rtl/game_judge.sv | 124 ++++++++++++
 tb/tb_game_judge.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_judge_pkg.sv
// Shared round-state encodings, text-store character codes and counter widths
// used by the round controller, the game judge and its divider.
package game_judge_pkg;

    typedef enum logic [1:0] {
        ST_SELECT    = 2'd0,
        ST_COUNTDOWN = 2'd1,
        ST_INGAME    = 2'd2,
        ST_FINISH    = 2'd3
    } round_state_t;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] TEXT_END    = 8'h00;

    localparam int SEC_W  = 7;
    localparam int WORD_W = 7;
    localparam int KEY_W  = 10;
    localparam int WPM_W  = 13;
    localparam int DIV_W  = 7;

    localparam logic [WPM_W-1:0] SECS_PER_MIN = 13'd60;

endpackage

// File: rtl/game_judge_wpm_div.sv
// Sequential restoring divider: first quotient bit is resolved on the start edge,
// done pulses N-1 cycles later; a zero divisor yields a zero quotient.
module wpm_div
    import game_judge_pkg::*;
#(
    parameter int N = WPM_W,
    parameter int D = DIV_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [D-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient
);

    localparam int CNT_W = $clog2(N);

    logic [D-1:0]     rem;
    logic [N-1:0]     quo;
    logic [D-1:0]     dsr;
    logic [CNT_W-1:0] cnt;

    logic [D-1:0] rem_src;
    logic [N-1:0] quo_src;
    logic [D-1:0] dsr_src;
    logic [D:0]   shifted;
    logic         fits;
    logic [D:0]   rem_nxt;
    logic [N-1:0] quo_nxt;
    logic         load;

    assign load = start && !busy;

    // On the start edge the step runs straight off the operands, saving a load cycle.
    always_comb begin
        rem_src = rem;
        quo_src = quo;
        dsr_src = dsr;
        if (load) begin
            rem_src = '0;
            quo_src = dividend;
            dsr_src = divisor;
        end
        shifted = {rem_src, quo_src[N-1]};
        fits    = shifted >= {1'b0, dsr_src};
        rem_nxt = fits ? shifted - {1'b0, dsr_src} : shifted;
        quo_nxt = {quo_src[N-2:0], fits};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem  <= '0;
            quo  <= '0;
            dsr  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else if (clr) begin
            rem  <= '0;
            quo  <= '0;
            dsr  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else if (load) begin
            rem  <= rem_nxt[D-1:0];
            quo  <= quo_nxt;
            dsr  <= divisor;
            cnt  <= CNT_W'(N-1);
            busy <= 1'b1;
            done <= 1'b0;
        end else if (busy) begin
            rem  <= rem_nxt[D-1:0];
            quo  <= quo_nxt;
            cnt  <= cnt - 1'b1;
            busy <= (cnt != CNT_W'(1));
            done <= (cnt == CNT_W'(1));
        end else begin
            done <= 1'b0;
        end
    end

    assign quotient = (dsr == '0) ? '0 : quo;

endmodule

// File: rtl/game_judge.sv
// Scores keystrokes during INGAME, raises finish on target/text end, then runs the
// WPM division; finish is registered one cycle after its condition, wpm 14 cycles after finish.
module game_judge
    import game_judge_pkg::*;
#(
    parameter int CLK_HZ = 100000000,
    parameter int IDX_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        state,
    input  logic              mode,
    input  logic [6:0]        value,
    input  logic              key_valid,
    input  logic [7:0]        key_code,
    input  logic [7:0]        target_char,
    output logic [IDX_W-1:0]  char_idx,
    output logic              finish,
    output logic [SEC_W-1:0]  elapsed,
    output logic [WORD_W-1:0] words,
    output logic [KEY_W-1:0]  correct,
    output logic [KEY_W-1:0]  errors,
    output logic [WPM_W-1:0]  wpm,
    output logic              wpm_valid
);

    localparam int PS_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    round_state_t     st;
    logic [PS_W-1:0]  presc;
    logic             setup;
    logic             active;
    logic             tick;
    logic             text_end;
    logic             key_hit;
    logic             target_met;
    logic             div_started;
    logic             div_start;
    logic             div_busy;
    logic             div_done;
    logic [WPM_W-1:0] div_quotient;
    logic [WPM_W-1:0] dividend;

    assign st         = round_state_t'(state);
    assign setup      = (st == ST_SELECT) || (st == ST_COUNTDOWN);
    assign active     = (st == ST_INGAME) && !finish;
    assign tick       = presc == PS_W'(CLK_HZ - 1);
    assign text_end   = target_char == TEXT_END;
    assign key_hit    = key_valid && !text_end;
    // mode is taken live so a mid-round change is honoured immediately
    assign target_met = mode ? (words >= value) : (elapsed >= value);
    assign div_start  = finish && !div_started && !div_busy;
    assign dividend   = WPM_W'(words) * SECS_PER_MIN;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc       <= '0;
            char_idx    <= '0;
            finish      <= 1'b0;
            elapsed     <= '0;
            words       <= '0;
            correct     <= '0;
            errors      <= '0;
            wpm         <= '0;
            wpm_valid   <= 1'b0;
            div_started <= 1'b0;
        end else if (setup) begin
            presc       <= '0;
            char_idx    <= '0;
            finish      <= 1'b0;
            elapsed     <= '0;
            words       <= '0;
            correct     <= '0;
            errors      <= '0;
            wpm         <= '0;
            wpm_valid   <= 1'b0;
            div_started <= 1'b0;
        end else begin
            if (active) begin
                presc <= tick ? '0 : presc + 1'b1;
                if (tick && elapsed != '1)
                    elapsed <= elapsed + 1'b1;
                if (key_hit) begin
                    if (key_code == target_char) begin
                        if (correct != '1)
                            correct <= correct + 1'b1;
                        char_idx <= char_idx + 1'b1;
                        if (target_char == ASCII_SPACE && words != '1)
                            words <= words + 1'b1;
                    end else if (errors != '1) begin
                        errors <= errors + 1'b1;
                    end
                end else if (text_end && correct != '0 && words != '1) begin
                    // the last word has no trailing space, so credit it at end of text
                    words <= words + 1'b1;
                end
                if (target_met || text_end)
                    finish <= 1'b1;
            end
            if (div_start)
                div_started <= 1'b1;
            if (div_done) begin
                wpm       <= div_quotient;
                wpm_valid <= 1'b1;
            end
        end
    end

    wpm_div #(
        .N(WPM_W),
        .D(DIV_W)
    ) u_wpm_div (
        .clk      (clk),
        .rst      (rst),
        .clr      (setup),
        .start    (div_start),
        .dividend (dividend),
        .divisor  (elapsed),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quotient)
    );

endmodule

// File: tb/tb_game_judge.sv
// Bench for game_judge: directed scenarios plus randomized rounds against a
// reference model built from the scoring rules.
module tb_game_judge;
    import game_judge_pkg::*;

    localparam int CLK_HZ = 10;
    localparam int IDX_W  = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       state;
    logic             mode;
    logic [6:0]       value;
    logic             key_valid;
    logic [7:0]       key_code;
    logic [7:0]       target_char;
    logic [IDX_W-1:0] char_idx;
    logic             finish;
    logic [6:0]       elapsed;
    logic [6:0]       words;
    logic [9:0]       correct;
    logic [9:0]       errors;
    logic [12:0]      wpm;
    logic             wpm_valid;

    always #5 clk = ~clk;

    game_judge #(.CLK_HZ(CLK_HZ), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .state(state), .mode(mode), .value(value),
        .key_valid(key_valid), .key_code(key_code), .target_char(target_char),
        .char_idx(char_idx), .finish(finish), .elapsed(elapsed), .words(words),
        .correct(correct), .errors(errors), .wpm(wpm), .wpm_valid(wpm_valid)
    );

    logic [7:0] text [0:63];
    assign target_char = (char_idx < IDX_W'(64)) ? text[char_idx[5:0]] : 8'h00;

    int n_vec = 0;
    int n_bad = 0;

    // reference model, advanced once per clock edge
    int m_cyc, m_el, m_words, m_correct, m_errors, m_idx, m_wpm, m_due, edge_no;
    bit m_fin, m_wpmv;

    typedef struct packed {
        logic [9:0]  idx;
        logic        fin;
        logic [6:0]  el;
        logic [6:0]  words;
        logic [9:0]  correct;
        logic [9:0]  errors;
        logic [12:0] wpm;
        logic        wpmv;
    } snap_t;

    function automatic snap_t dut_snap();
        snap_t s;
        s = '{char_idx, finish, elapsed, words, correct, errors, wpm, wpm_valid};
        return s;
    endfunction

    function automatic snap_t model_snap();
        snap_t s;
        s = '{10'(m_idx), m_fin, 7'(m_el), 7'(m_words), 10'(m_correct), 10'(m_errors),
              13'(m_wpm), m_wpmv};
        return s;
    endfunction

    function automatic string show(input snap_t s);
        return $sformatf("idx=%0d fin=%0d el=%0d words=%0d ok=%0d err=%0d wpm=%0d wv=%0d",
                         s.idx, s.fin, s.el, s.words, s.correct, s.errors, s.wpm, s.wpmv);
    endfunction

    function automatic void model_clear();
        m_cyc = 0; m_el = 0; m_words = 0; m_correct = 0; m_errors = 0;
        m_idx = 0; m_wpm = 0; m_due = -1; m_fin = 0; m_wpmv = 0;
    endfunction

    function automatic void set_text(input string s);
        for (int i = 0; i < 64; i++) text[i] = 8'h00;
        for (int i = 0; i < s.len() && i < 63; i++) text[i] = s[i];
    endfunction

    // One clock with an optional keystroke; the model sees the same pre-edge inputs.
    task automatic cyc(input bit kv, input logic [7:0] kc);
        int tc;
        bit met;
        key_valid = kv;
        key_code  = kc;
        tc = int'(text[m_idx]);
        edge_no++;
        if (state == 2'd0 || state == 2'd1) begin
            model_clear();
        end else begin
            if (state == 2'd2 && !m_fin) begin
                met = (mode ? (m_words >= int'(value)) : (m_el >= int'(value))) || tc == 0;
                m_cyc++;
                m_el = m_cyc / CLK_HZ;
                if (m_el > 127) m_el = 127;
                if (kv && tc != 0) begin
                    if (int'(kc) == tc) begin
                        if (m_correct < 1023) m_correct++;
                        m_idx++;
                        if (tc == 32 && m_words < 127) m_words++;
                    end else if (m_errors < 1023) begin
                        m_errors++;
                    end
                end else if (tc == 0 && m_correct > 0 && m_words < 127) begin
                    m_words++;
                end
                if (met) begin
                    m_fin = 1;
                    m_due = edge_no + 14;
                end
            end
            if (edge_no == m_due) begin
                m_wpmv = 1;
                m_wpm  = (m_el == 0) ? 0 : (m_words * 60) / m_el;
            end
        end
        @(posedge clk);
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; state = 2'd0; mode = 1'b0; value = 7'd0;
        key_valid = 1'b0; key_code = 8'h00; edge_no = 0;
        set_text("abc");
        model_clear();
        repeat (3) @(negedge clk);
        n_vec++;
        if (dut_snap() !== snap_t'(0)) begin
            n_bad++;
            $display("FAIL reset: got %s want all zero", show(dut_snap()));
        end
        rst = 1'b0;
        cyc(0, 8'h00);
        n_vec++;
        if (dut_snap() !== model_snap()) begin
            n_bad++;
            $display("FAIL reset_select: got %s want %s", show(dut_snap()), show(model_snap()));
        end
    endtask

    task automatic test_timed();
        set_text("aaaa"); mode = 1'b0; value = 7'd3; state = 2'd0;
        cyc(0, 8'h00); cyc(0, 8'h00);
        state = 2'd2;
        for (int k = 1; k <= 50; k++) begin
            cyc(0, 8'h00);
            n_vec++;
            if (dut_snap() !== model_snap()) begin
                n_bad++;
                $display("FAIL timed[%0d]: got %s want %s", k, show(dut_snap()), show(model_snap()));
            end
            if (k == 30) begin
                n_vec++;
                if (elapsed !== 7'd3 || finish !== 1'b0) begin
                    n_bad++;
                    $display("FAIL timed_el3: got el=%0d fin=%0d want el=3 fin=0", elapsed, finish);
                end
            end
            if (k == 31) begin
                n_vec++;
                if (finish !== 1'b1) begin
                    n_bad++;
                    $display("FAIL timed_finish: got fin=%0d want 1", finish);
                end
            end
            if (k == 44) begin
                n_vec++;
                if (wpm_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL timed_wv_early: got wv=%0d want 0", wpm_valid);
                end
            end
            if (k == 45) begin
                n_vec++;
                if (wpm_valid !== 1'b1 || wpm !== 13'd0) begin
                    n_bad++;
                    $display("FAIL timed_wpm: got wv=%0d wpm=%0d want wv=1 wpm=0", wpm_valid, wpm);
                end
            end
        end
        state = 2'd3;
        repeat (3) cyc(0, 8'h00);
        n_vec++;
        if (finish !== 1'b1 || wpm_valid !== 1'b1 || elapsed !== 7'd3) begin
            n_bad++;
            $display("FAIL timed_hold: got fin=%0d wv=%0d el=%0d want 1 1 3", finish, wpm_valid, elapsed);
        end
        state = 2'd0;
        cyc(0, 8'h00);
        n_vec++;
        if (dut_snap() !== snap_t'(0)) begin
            n_bad++;
            $display("FAIL timed_clear: got %s want all zero", show(dut_snap()));
        end
    endtask

    task automatic test_words();
        string keys;
        keys = "ab cd ";
        set_text("ab cd ef"); mode = 1'b1; value = 7'd2; state = 2'd0;
        cyc(0, 8'h00);
        state = 2'd2;
        for (int i = 0; i < keys.len(); i++) begin
            repeat ($urandom_range(0, 2)) cyc(0, 8'h00);
            cyc(1, keys[i]);
            n_vec++;
            if (dut_snap() !== model_snap()) begin
                n_bad++;
                $display("FAIL words[%0d]: got %s want %s", i, show(dut_snap()), show(model_snap()));
            end
        end
        n_vec++;
        if (words !== 7'd2 || finish !== 1'b0) begin
            n_bad++;
            $display("FAIL words_pre: got words=%0d fin=%0d want 2 0", words, finish);
        end
        cyc(0, 8'h00);
        n_vec++;
        if (finish !== 1'b1 || correct !== 10'd6 || char_idx !== 10'd6) begin
            n_bad++;
            $display("FAIL words_finish: got fin=%0d ok=%0d idx=%0d want 1 6 6", finish, correct, char_idx);
        end
        cyc(1, "e"); cyc(1, "f");
        n_vec++;
        if (correct !== 10'd6 || char_idx !== 10'd6 || words !== 7'd2 || errors !== 10'd0) begin
            n_bad++;
            $display("FAIL words_frozen: got ok=%0d idx=%0d words=%0d err=%0d want 6 6 2 0",
                     correct, char_idx, words, errors);
        end
        repeat (15) cyc(0, 8'h00);
        n_vec++;
        if (dut_snap() !== model_snap()) begin
            n_bad++;
            $display("FAIL words_wpm: got %s want %s", show(dut_snap()), show(model_snap()));
        end
        state = 2'd0;
        cyc(0, 8'h00);
    endtask

    task automatic test_errors();
        set_text("abc"); mode = 1'b1; value = 7'd100; state = 2'd0;
        cyc(0, 8'h00);
        state = 2'd2;
        cyc(1, "x"); cyc(1, "x"); cyc(1, "x"); cyc(1, "a");
        n_vec++;
        if (errors !== 10'd3 || correct !== 10'd1 || char_idx !== 10'd1) begin
            n_bad++;
            $display("FAIL errors: got err=%0d ok=%0d idx=%0d want 3 1 1", errors, correct, char_idx);
        end
        n_vec++;
        if (dut_snap() !== model_snap()) begin
            n_bad++;
            $display("FAIL errors_model: got %s want %s", show(dut_snap()), show(model_snap()));
        end
        state = 2'd0;
        cyc(0, 8'h00);
    endtask

    task automatic test_text_end();
        set_text("hi"); mode = 1'b0; value = 7'd100; state = 2'd0;
        cyc(0, 8'h00);
        state = 2'd2;
        repeat (20) cyc(0, 8'h00);
        cyc(1, "h"); cyc(1, "i");
        cyc(0, 8'h00);
        n_vec++;
        if (finish !== 1'b1 || words !== 7'd1 || elapsed !== 7'd2) begin
            n_bad++;
            $display("FAIL textend: got fin=%0d words=%0d el=%0d want 1 1 2", finish, words, elapsed);
        end
        repeat (13) cyc(0, 8'h00);
        n_vec++;
        if (wpm_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL textend_wv_early: got wv=%0d want 0", wpm_valid);
        end
        cyc(0, 8'h00);
        n_vec++;
        if (wpm_valid !== 1'b1 || wpm !== 13'd30) begin
            n_bad++;
            $display("FAIL textend_wpm: got wv=%0d wpm=%0d want 1 30", wpm_valid, wpm);
        end
        n_vec++;
        if (dut_snap() !== model_snap()) begin
            n_bad++;
            $display("FAIL textend_model: got %s want %s", show(dut_snap()), show(model_snap()));
        end
        state = 2'd0;
        cyc(0, 8'h00);
    endtask

    task automatic test_tick_key();
        set_text("abcdef"); mode = 1'b0; value = 7'd1; state = 2'd0;
        cyc(0, 8'h00);
        state = 2'd2;
        repeat (CLK_HZ - 1) cyc(0, 8'h00);
        cyc(1, "a");
        n_vec++;
        if (elapsed !== 7'd1 || correct !== 10'd1 || finish !== 1'b0) begin
            n_bad++;
            $display("FAIL tickkey: got el=%0d ok=%0d fin=%0d want 1 1 0", elapsed, correct, finish);
        end
        cyc(0, 8'h00);
        cyc(1, "b");
        n_vec++;
        if (finish !== 1'b1 || correct !== 10'd1 || char_idx !== 10'd1) begin
            n_bad++;
            $display("FAIL tickkey_finkey: got fin=%0d ok=%0d idx=%0d want 1 1 1", finish, correct, char_idx);
        end
        n_vec++;
        if (dut_snap() !== model_snap()) begin
            n_bad++;
            $display("FAIL tickkey_model: got %s want %s", show(dut_snap()), show(model_snap()));
        end
        state = 2'd0;
        cyc(0, 8'h00);
    endtask

    task automatic test_abort();
        set_text("abcdef"); mode = 1'b0; value = 7'd0; state = 2'd0;
        cyc(0, 8'h00);
        state = 2'd2;
        cyc(0, 8'h00);
        n_vec++;
        if (finish !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_val0: got fin=%0d want 1", finish);
        end
        repeat (5) cyc(0, 8'h00);
        state = 2'd0;
        cyc(0, 8'h00);
        n_vec++;
        if (dut_snap() !== snap_t'(0)) begin
            n_bad++;
            $display("FAIL abort_clear: got %s want all zero", show(dut_snap()));
        end
        state = 2'd1;
        cyc(0, 8'h00); cyc(0, 8'h00);
        state = 2'd2; value = 7'd50;
        cyc(1, "a");
        for (int k = 0; k < 20; k++) begin
            cyc(0, 8'h00);
            n_vec++;
            if (dut_snap() !== model_snap() || wpm_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL abort_reenter[%0d]: got %s want %s", k, show(dut_snap()), show(model_snap()));
            end
        end
        #2 rst = 1'b1;
        #1;
        model_clear();
        n_vec++;
        if (dut_snap() !== snap_t'(0)) begin
            n_bad++;
            $display("FAIL abort_rst: got %s want all zero", show(dut_snap()));
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) cyc(0, 8'h00);
        n_vec++;
        if (dut_snap() !== model_snap()) begin
            n_bad++;
            $display("FAIL abort_after_rst: got %s want %s", show(dut_snap()), show(model_snap()));
        end
        state = 2'd0;
        cyc(0, 8'h00);
    endtask

    task automatic test_random();
        string s;
        int len;
        int since_fin;
        logic [7:0] k;
        for (int r = 0; r < 12; r++) begin
            len = $urandom_range(3, 30);
            s = "";
            for (int i = 0; i < len; i++)
                s = {s, string'(($urandom_range(0, 4) == 0) ? 8'h20 : 8'(8'h61 + $urandom_range(0, 5)))};
            set_text(s);
            mode  = 1'($urandom_range(0, 1));
            value = 7'($urandom_range(0, 8));
            state = 2'd0;
            repeat ($urandom_range(1, 2)) cyc(0, 8'h00);
            state = 2'd1;
            repeat ($urandom_range(1, 3)) cyc(0, 8'h00);
            state = 2'd2;
            since_fin = 0;
            for (int c = 0; c < 120 && since_fin < 18; c++) begin
                if ($urandom_range(0, 39) == 0) mode = ~mode;
                if (target_char != 8'h00 && $urandom_range(0, 3) != 0) k = target_char;
                else k = 8'(8'h61 + $urandom_range(0, 5));
                cyc(1'($urandom_range(0, 2) != 0), k);
                if (m_fin) since_fin++;
                n_vec++;
                if (dut_snap() !== model_snap()) begin
                    n_bad++;
                    $display("FAIL random[%0d.%0d]: got %s want %s", r, c, show(dut_snap()), show(model_snap()));
                end
            end
            state = 2'd3;
            repeat (3) cyc(1, 8'h61);
            n_vec++;
            if (dut_snap() !== model_snap()) begin
                n_bad++;
                $display("FAIL random_fin[%0d]: got %s want %s", r, show(dut_snap()), show(model_snap()));
            end
        end
        state = 2'd0;
        cyc(0, 8'h00);
    endtask

    initial begin
        test_reset();
        test_timed();
        test_words();
        test_errors();
        test_text_end();
        test_tick_key();
        test_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
